// File: rtl/aes_key_expand_multi_pkg.sv
// Shared types and helpers for the multi-length AES key expander.
// Key-length decode, FSM states, RotWord and GF(2^8) xtime.
package aes_key_expand_multi_pkg;

   typedef enum logic [1:0] {
      KL_128  = 2'b00,
      KL_192  = 2'b01,
      KL_256  = 2'b10,
      KL_RSVD = 2'b11
   } key_len_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SUBWORD,
      S_EXPAND,
      S_DONE
   } state_e;

   function automatic logic [3:0] nk_of(key_len_e kl);
      case (kl)
         KL_128:  return 4'd4;
         KL_192:  return 4'd6;
         KL_256:  return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(key_len_e kl);
      case (kl)
         KL_128:  return 4'd10;
         KL_192:  return 4'd12;
         KL_256:  return 4'd14;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic [31:0] rot_word(logic [31:0] t);
      return {t[23:0], t[31:24]};
   endfunction

   // Multiply by x in GF(2^8), reduction polynomial 0x11B.
   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_expand_multi_if.sv
// Request/response bundle between a key source and the expander.
// master drives the request side; slave is the expander.
interface aes_key_expand_multi_if #(
   parameter int MAX_KEY_BITS = 256
);
   localparam int SLOTS = MAX_KEY_BITS / 32 + 7;

   logic                      valid_i;
   logic [1:0]                key_len_i;
   logic [MAX_KEY_BITS-1:0]   key_i;
   logic                      ready_o;
   logic                      valid_o;
   logic                      err_o;
   logic [3:0]                nr_o;
   logic [SLOTS-1:0][127:0]   round_key_o;

   modport master (
      output valid_i, key_len_i, key_i,
      input  ready_o, valid_o, err_o, nr_o, round_key_o
   );

   modport slave (
      input  valid_i, key_len_i, key_i,
      output ready_o, valid_o, err_o, nr_o, round_key_o
   );
endinterface

// File: rtl/aes_key_expand_multi_sub_word.sv
// AES SubWord: four parallel forward S-box lookups, purely combinational.
module aes_key_expand_multi_sub_word (
   input  logic [31:0] word,
   output logic [31:0] subst
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign subst = {SBOX[word[31:24]], SBOX[word[23:16]],
                   SBOX[word[15:8]],  SBOX[word[7:0]]};
endmodule

// File: rtl/aes_key_expand_multi.sv
// Word-serial AES-128/192/256 key expander; one schedule word per cycle, ready only when idle.
// KEY_EXP_SBOX_REG_EN registers the S-box output, adding one S_SUBWORD cycle per S-box word.
module aes_key_expand_multi
   import aes_key_expand_multi_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256
) (
   input logic                   clk,
   input logic                   rst_n,
   aes_key_expand_multi_if.slave bus
);
   localparam int MAX_NR = MAX_KEY_BITS / 32 + 6;
   localparam int SLOTS  = MAX_NR + 1;
   localparam int NW_MAX = 4 * SLOTS;
   localparam int IW     = $clog2(NW_MAX);
   localparam int KW     = MAX_KEY_BITS / 32;

   state_e                   state, state_nxt;
   logic [NW_MAX-1:0][31:0]  w;
   logic [IW-1:0]            idx;
   logic [2:0]               cnt, cnt_nxt;
   logic [3:0]               nk_q, nr_q;
   logic [7:0]               rcon;
   logic                     valid_q, err_q;

   key_len_e                 req_len;
   logic [3:0]               req_nk;
   logic                     req_bad, accept, reject;
   logic [31:0]              t, sub_in, sub_out, sbox_val, mix, new_word;
   logic                     need_sbox, last_word;

   assign req_len = key_len_e'(bus.key_len_i);
   assign req_nk  = nk_of(req_len);
   assign req_bad = (req_len == KL_RSVD) || (32 * int'(req_nk) > MAX_KEY_BITS);
   assign accept  = bus.valid_i && (state == S_IDLE) && !req_bad;
   assign reject  = bus.valid_i && (state == S_IDLE) && req_bad;

   // cnt tracks i mod Nk so no divider is needed.
   assign cnt_nxt   = ({1'b0, cnt} == nk_q - 4'd1) ? 3'd0 : cnt + 3'd1;
   assign need_sbox = (cnt == 3'd0) || (nk_q == 4'd8 && cnt == 3'd4);
   assign last_word = (idx == IW'({nr_q, 2'b11}));

   assign t      = w[idx - IW'(1)];
   assign sub_in = (cnt == 3'd0) ? rot_word(t) : t;

   aes_key_expand_multi_sub_word u_sub_word (
      .word  (sub_in),
      .subst (sub_out)
   );

`ifdef KEY_EXP_SBOX_REG_EN
   logic [31:0] sbox_q;
   logic        need_sbox_nxt;

   assign need_sbox_nxt = (cnt_nxt == 3'd0) || (nk_q == 4'd8 && cnt_nxt == 3'd4);
   assign sbox_val      = sbox_q;

   always_ff @(posedge clk) begin
      if (!rst_n)                 sbox_q <= '0;
      else if (state == S_SUBWORD) sbox_q <= sub_out;
   end
`else
   assign sbox_val = sub_out;
`endif

   assign mix = (cnt == 3'd0) ? (sbox_val ^ {rcon, 24'h0}) :
                need_sbox     ? sbox_val : t;
   assign new_word = w[idx - IW'(nk_q)] ^ mix;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
`ifdef KEY_EXP_SBOX_REG_EN
            if (accept) state_nxt = S_SUBWORD;
`else
            if (accept) state_nxt = S_EXPAND;
`endif
         end
         S_SUBWORD: state_nxt = S_EXPAND;
         S_EXPAND: begin
            if (last_word) state_nxt = S_DONE;
`ifdef KEY_EXP_SBOX_REG_EN
            else if (need_sbox_nxt) state_nxt = S_SUBWORD;
`endif
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w       <= '0;
         idx     <= '0;
         cnt     <= '0;
         nk_q    <= '0;
         nr_q    <= '0;
         rcon    <= 8'h01;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= (state == S_DONE);
         err_q   <= reject;
         if (accept) begin
            // Clearing first keeps slots above Nr at zero for shorter keys.
            w <= '0;
            for (int j = 0; j < KW; j++) begin
               if (j < int'(req_nk)) w[j] <= bus.key_i[MAX_KEY_BITS-1-32*j -: 32];
            end
            nk_q <= req_nk;
            nr_q <= nr_of(req_len);
            idx  <= IW'(req_nk);
            cnt  <= 3'd0;
            rcon <= 8'h01;
         end else if (state == S_EXPAND) begin
            w[idx] <= new_word;
            idx    <= idx + IW'(1);
            cnt    <= cnt_nxt;
            if (cnt == 3'd0) rcon <= xtime(rcon);
         end
      end
   end

   assign bus.ready_o = (state == S_IDLE);
   assign bus.valid_o = valid_q;
   assign bus.err_o   = err_q;
   assign bus.nr_o    = nr_q;

   always_comb begin
      for (int r = 0; r < SLOTS; r++) begin
         bus.round_key_o[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   end

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Scoreboard bench: directed FIPS-197 key vectors, rejection, held valid and mid-run reset.
module tb_aes_key_expand_multi;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_key_expand_multi_if #(.MAX_KEY_BITS(256)) if0 ();
   aes_key_expand_multi_if #(.MAX_KEY_BITS(128)) if1 ();

   aes_key_expand_multi #(.MAX_KEY_BITS(256)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   aes_key_expand_multi #(.MAX_KEY_BITS(128)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

`ifdef KEY_EXP_SBOX_REG_EN
   localparam int LAT128 = 51, LAT192 = 55, LAT256 = 66;
`else
   localparam int LAT128 = 41, LAT192 = 47, LAT256 = 53;
`endif

   localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK192_1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
   localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] RK256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
   localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

   typedef struct {
      bit           dut;
      bit           is_err;
      int           cyc;
      logic [3:0]   nr;
      int           ia;
      logic [127:0] va;
      int           ib;
      logic [127:0] vb;
      int           zfrom;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(bit d, bit e, logic [3:0] nr, int ia, logic [127:0] va,
                               int ib, logic [127:0] vb, int zf);
      exp_t x;
      x.dut = d; x.is_err = e; x.cyc = 0; x.nr = nr;
      x.ia = ia; x.va = va; x.ib = ib; x.vb = vb; x.zfrom = zf;
      return x;
   endfunction

   function automatic logic [127:0] rk(input bit d, input int s);
      if (d) return (s < 11) ? if1.round_key_o[s] : '0;
      return if0.round_key_o[s];
   endfunction

   task automatic chk_out(input bit d, input bit v, input bit e, input bit rdy, input logic [3:0] nr);
      exp_t x;
      if (sb.size() == 0) begin
         chk("spurious_output", {126'd0, v, e}, 128'd0);
         return;
      end
      x = sb.pop_front();
      chk("out_dut", {127'd0, d}, {127'd0, x.dut});
      chk("out_kind", {126'd0, v, e}, x.is_err ? 128'd1 : 128'd2);
      chk("out_cycle", 128'(cyc), 128'(x.cyc));
      chk("out_nr", {124'd0, nr}, {124'd0, x.nr});
      chk($sformatf("rk[%0d]", x.ia), rk(d, x.ia), x.va);
      chk($sformatf("rk[%0d]", x.ib), rk(d, x.ib), x.vb);
      for (int s = x.zfrom; s < 15; s++) chk($sformatf("rk_zero[%0d]", s), rk(d, s), '0);
      if (x.is_err) chk("err_ready", {127'd0, rdy}, 128'd1);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (if0.valid_o || if0.err_o) chk_out(1'b0, if0.valid_o, if0.err_o, if0.ready_o, if0.nr_o);
         if (if1.valid_o || if1.err_o) chk_out(1'b1, if1.valid_o, if1.err_o, if1.ready_o, if1.nr_o);
      end
   end

   // Called at a negedge; returns just after the accepting posedge. valid_i is left high.
   task automatic req(input bit d, input logic [1:0] kl, input logic [255:0] key,
                      input exp_t x, input int lat);
      int n = 0;
      if (d) begin
         if1.valid_i = 1'b1; if1.key_len_i = kl; if1.key_i = key[255:128];
      end else begin
         if0.valid_i = 1'b1; if0.key_len_i = kl; if0.key_i = key;
      end
      while (!(d ? if1.ready_o : if0.ready_o)) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            chk("ready_timeout", {127'd0, (d ? if1.ready_o : if0.ready_o)}, 128'd1);
            return;
         end
      end
      x.cyc = cyc + 1 + lat;
      sb.push_back(x);
      @(posedge clk);
   endtask

   task automatic drop_valid();
      if0.valid_i = 1'b0;
      if1.valid_i = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 128'(sb.size()), 128'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, {127'd0, if0.ready_o}, 128'd1);
      chk({tag, "_valid"}, {127'd0, if0.valid_o}, 128'd0);
      chk({tag, "_err"},   {127'd0, if0.err_o},   128'd0);
      chk({tag, "_nr"},    {124'd0, if0.nr_o},    128'd0);
      for (int s = 0; s < 15; s++) chk($sformatf("%s_rk[%0d]", tag, s), rk(1'b0, s), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      if0.valid_i = 1'b0; if0.key_len_i = 2'b00; if0.key_i = '0;
      if1.valid_i = 1'b0; if1.key_len_i = 2'b00; if1.key_i = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset("reset");

      // AES-128
      req(1'b0, 2'b00, {K128, 128'h0}, mk(0, 0, 4'd10, 1, RK128_1, 10, RK128_10, 11), LAT128);
      @(negedge clk); drop_valid(); drain();

      // Reserved length, then 192-bit key on the 128-bit-only instance
      @(negedge clk);
      req(1'b0, 2'b11, {K128, 128'h0}, mk(0, 1, 4'd10, 10, RK128_10, 1, RK128_1, 11), 0);
      @(negedge clk); drop_valid(); drain();
      @(negedge clk);
      req(1'b1, 2'b01, {K192, 64'h0}, mk(1, 1, 4'd0, 0, '0, 10, '0, 15), 0);
      @(negedge clk); drop_valid(); drain();

      // AES-192
      @(negedge clk);
      req(1'b0, 2'b01, {K192, 64'h0}, mk(0, 0, 4'd12, 12, RK192_12, 1, RK192_1, 13), LAT192);
      @(negedge clk); drop_valid(); drain();

      // AES-256
      @(negedge clk);
      req(1'b0, 2'b10, K256, mk(0, 0, 4'd14, 14, RK256_14, 2, RK256_2, 15), LAT256);
      @(negedge clk); drop_valid(); drain();

      // valid_i held high across a run while the key changes underneath
      @(negedge clk);
      req(1'b0, 2'b00, {K128, 128'h0}, mk(0, 0, 4'd10, 1, RK128_1, 10, RK128_10, 11), LAT128);
      @(negedge clk);
      req(1'b0, 2'b10, K256, mk(0, 0, 4'd14, 14, RK256_14, 2, RK256_2, 15), LAT256);
      @(negedge clk); drop_valid(); drain();
      repeat (20) @(negedge clk);

      // Reset in the middle of an expansion discards the schedule
      req(1'b0, 2'b00, {K128, 128'h0}, mk(0, 0, 4'd10, 1, RK128_1, 10, RK128_10, 11), LAT128);
      @(negedge clk); drop_valid();
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      @(negedge clk);
      check_reset("midrst");
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      req(1'b0, 2'b00, {K128, 128'h0}, mk(0, 0, 4'd10, 1, RK128_1, 10, RK128_10, 11), LAT128);
      @(negedge clk); drop_valid(); drain();

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
